mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 216 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction, issues at most one data-memory
// request for it, and hands the finished result to WB through a registered output slot.
module mem_stage #(
    parameter int EX2MEM_W = 107,
    parameter int MEM2WB_W = 102
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [EX2MEM_W-1:0] ex2mem_bus_i,
    input  logic                ex2mem_valid_i,
    output logic                mem_allowin_o,
    output logic [MEM2WB_W-1:0] mem2wb_bus_o,
    output logic                mem2wb_valid_o,
    input  logic                wb_allowin_i,
    output logic                dm_req_o,
    output logic                dm_we_o,
    output logic [31:0]         dm_addr_o,
    output logic [3:0]          dm_wstrb_o,
    output logic [31:0]         dm_wdata_o,
    input  logic                dm_ready_i,
    input  logic [31:0]         dm_rdata_i,
    output logic [4:0]          forward_mem_dest_o,
    output logic [31:0]         forward_mem_data_o,
    output logic                forward_mem_busy_o,
    output logic [31:0]         ctl_mem_pc_o,
    output logic                dbg_mem_state
);

    // Handshake: a word moves across an interface at a rising edge exactly when the
    // sender's valid and the receiver's allowin are both high in the preceding cycle;
    // an unaccepted word is held unchanged by its sender.

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t      state;
    logic        in_valid;
    logic        done_hold;
    logic [31:0] held_rdata;

    logic [4:0]  r_wdest;
    logic        r_we;
    logic        r_rd;
    logic        r_wr;
    logic [1:0]  r_size;
    logic        r_sext;
    logic [31:0] r_alu;
    logic [31:0] r_sd;
    logic [31:0] r_pc;

    logic [4:0]  ex_wdest;
    logic        ex_we;
    logic        ex_rd;
    logic        ex_wr;
    logic [1:0]  ex_size;
    logic        ex_sext;
    logic [31:0] ex_alu;
    logic [31:0] ex_sd;
    logic [31:0] ex_pc;
    logic        ex_memop;

    logic        memop;
    logic        misaligned;
    logic        rsp;
    logic        in_done;
    logic        out_free;
    logic        transfer;
    logic        accept;
    logic        we_eff;

    logic [31:0] rdata_eff;
    logic [31:0] lane_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val;
    logic [31:0] result;
    logic [31:0] dbg_addr;
    logic [3:0]  st_strb;
    logic [31:0] st_data;

    // size 2'b11 falls into the word case
    function automatic logic aligned_f(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            2'b00:   return 1'b1;
            2'b01:   return !addr[0];
            default: return addr == 2'b00;
        endcase
    endfunction

    assign {ex_wdest, ex_we, ex_rd, ex_wr, ex_size, ex_sext} = ex2mem_bus_i[106:96];
    assign ex_alu   = ex2mem_bus_i[95:64];
    assign ex_sd    = ex2mem_bus_i[63:32];
    assign ex_pc    = ex2mem_bus_i[31:0];
    assign ex_memop = (ex_rd || ex_wr) && aligned_f(ex_size, ex_alu[1:0]);

    assign misaligned = (r_rd || r_wr) && !aligned_f(r_size, r_alu[1:0]);
    assign memop      = (r_rd || r_wr) && !misaligned;
    assign rsp        = done_hold || dm_ready_i;
    assign in_done    = in_valid && (!memop || (state == S_REQ && rsp));
    assign out_free   = !mem2wb_valid_o || wb_allowin_i;
    assign transfer   = in_done && out_free;
    assign mem_allowin_o = !rst && (!in_valid || transfer);
    assign accept     = ex2mem_valid_i && mem_allowin_o;
    assign we_eff     = r_we && !misaligned;

    always_comb begin
        rdata_eff = done_hold ? held_rdata : dm_rdata_i;
        lane_word = rdata_eff >> {r_alu[1:0], 3'b000};
        ld_byte   = lane_word[7:0];
        ld_half   = r_alu[1] ? rdata_eff[31:16] : rdata_eff[15:0];
        case (r_size)
            2'b00:   load_val = {{24{r_sext & ld_byte[7]}}, ld_byte};
            2'b01:   load_val = {{16{r_sext & ld_half[15]}}, ld_half};
            default: load_val = rdata_eff;
        endcase
        if (misaligned)
            result = 32'h0;
        else if (r_rd)
            result = load_val;
        else
            result = r_alu;
        dbg_addr = memop ? r_alu : 32'h0;
    end

    always_comb begin
        case (r_size)
            2'b00: begin
                st_strb = 4'b0001 << r_alu[1:0];
                st_data = {4{r_sd[7:0]}};
            end
            2'b01: begin
                st_strb = 4'b0011 << {r_alu[1], 1'b0};
                st_data = {2{r_sd[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = r_sd;
            end
        endcase
    end

    // once a response is latched the request drops so memory sees exactly one access
    assign dm_req_o   = !rst && (state == S_REQ) && !done_hold;
    assign dm_we_o    = dm_req_o && r_wr;
    assign dm_addr_o  = {r_alu[31:2], 2'b00};
    assign dm_wstrb_o = dm_we_o ? st_strb : 4'b0000;
    assign dm_wdata_o = st_data;

    assign forward_mem_dest_o = (in_valid && we_eff) ? r_wdest : 5'd0;
    assign forward_mem_data_o = in_valid ? result : 32'h0;
    assign forward_mem_busy_o = in_valid && r_rd && !in_done;
    assign ctl_mem_pc_o       = in_valid ? r_pc : 32'h0;
    assign dbg_mem_state      = (state == S_REQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            in_valid       <= 1'b0;
            done_hold      <= 1'b0;
            held_rdata     <= 32'h0;
            r_wdest        <= 5'd0;
            r_we           <= 1'b0;
            r_rd           <= 1'b0;
            r_wr           <= 1'b0;
            r_size         <= 2'b00;
            r_sext         <= 1'b0;
            r_alu          <= 32'h0;
            r_sd           <= 32'h0;
            r_pc           <= 32'h0;
            mem2wb_valid_o <= 1'b0;
            mem2wb_bus_o   <= '0;
        end else begin
            if (accept) begin
                in_valid <= 1'b1;
                r_wdest  <= ex_wdest;
                r_we     <= ex_we;
                r_rd     <= ex_rd;
                r_wr     <= ex_wr;
                r_size   <= ex_size;
                r_sext   <= ex_sext;
                r_alu    <= ex_alu;
                r_sd     <= ex_sd;
                r_pc     <= ex_pc;
            end else if (transfer) begin
                in_valid <= 1'b0;
            end

            if (transfer) begin
                mem2wb_valid_o <= 1'b1;
                mem2wb_bus_o   <= {r_wdest, we_eff, result, dbg_addr, r_pc};
            end else if (wb_allowin_i) begin
                mem2wb_valid_o <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (accept && ex_memop)
                        state <= S_REQ;
                end
                S_REQ: begin
                    if (rsp && out_free) begin
                        done_hold <= 1'b0;
                        state     <= (accept && ex_memop) ? S_REQ : S_IDLE;
                    end else if (dm_ready_i && !done_hold) begin
                        done_hold  <= 1'b1;
                        held_rdata <= dm_rdata_i;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: a two-slot transaction model (stage + WB slot) and a
// hashed memory predict every output each cycle; directed scenarios cover the corner cases.
module tb_mem_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [106:0] ex_bus;
    logic         ex_valid;
    logic         mem_allowin;
    logic [101:0] wb_bus;
    logic         wb_valid;
    logic         wb_allowin;
    logic         dm_req;
    logic         dm_we;
    logic [31:0]  dm_addr;
    logic [3:0]   dm_wstrb;
    logic [31:0]  dm_wdata;
    logic         dm_ready;
    logic [31:0]  dm_rdata;
    logic [4:0]   fwd_dest;
    logic [31:0]  fwd_data;
    logic         fwd_busy;
    logic [31:0]  ctl_pc;
    logic         dbg_state;
    logic [31:0]  noise;

    mem_stage #(.EX2MEM_W(107), .MEM2WB_W(102)) dut (
        .clk(clk), .rst(rst),
        .ex2mem_bus_i(ex_bus), .ex2mem_valid_i(ex_valid), .mem_allowin_o(mem_allowin),
        .mem2wb_bus_o(wb_bus), .mem2wb_valid_o(wb_valid), .wb_allowin_i(wb_allowin),
        .dm_req_o(dm_req), .dm_we_o(dm_we), .dm_addr_o(dm_addr), .dm_wstrb_o(dm_wstrb),
        .dm_wdata_o(dm_wdata), .dm_ready_i(dm_ready), .dm_rdata_i(dm_rdata),
        .forward_mem_dest_o(fwd_dest), .forward_mem_data_o(fwd_data),
        .forward_mem_busy_o(fwd_busy), .ctl_mem_pc_o(ctl_pc), .dbg_mem_state(dbg_state)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // memory contents: a fixed hash of the word address, one pinned word
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_1000) return 32'h80FF_0000;
        return ((a ^ 32'h5A5A_0F0F) * 32'h9E37_79B1) + 32'h0123_4567;
    endfunction

    assign dm_rdata = dm_ready ? mem_word(dm_addr) : noise;

    function automatic logic [106:0] make_bus(input logic [4:0] wd, input logic we, input logic rd,
                                              input logic wr, input logic [1:0] sz, input logic sx,
                                              input logic [31:0] alu, input logic [31:0] sd,
                                              input logic [31:0] pc);
        return {wd, we, rd, wr, sz, sx, alu, sd, pc};
    endfunction

    function automatic logic is_aligned(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 1'b1;
        if (sz == 2'd1) return a[0] == 1'b0;
        return a[1:0] == 2'd0;
    endfunction

    function automatic logic [101:0] ref_wb(input logic [106:0] b);
        logic [4:0] wd; logic we, rd, wr, sx; logic [1:0] sz;
        logic [31:0] alu, pc, w, v; int sh;
        {wd, we, rd, wr, sz, sx, alu} = b[106:64];
        pc = b[31:0];
        if ((rd || wr) && !is_aligned(sz, alu)) return {wd, 1'b0, 32'h0, 32'h0, pc};
        if (!rd) return {wd, we, alu, (wr ? alu : 32'h0), pc};
        w  = mem_word({alu[31:2], 2'b00});
        sh = int'(alu[1:0]);
        if (sz == 2'd0) begin
            v = (w >> (8 * sh)) & 32'hFF;
            if (sx && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (w >> (16 * (sh / 2))) & 32'hFFFF;
            if (sx && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return {wd, we, v, alu, pc};
    endfunction

    function automatic logic [3:0] ref_strb(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 4'b0001 << a[1:0];
        if (sz == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'd0) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (sz == 2'd1) return {d[15:0], d[15:0]};
        return d;
    endfunction

    function automatic logic [106:0] rand_bus();
        int kind; logic rd, wr, we;
        kind = $urandom_range(0, 2);
        rd = (kind == 1);
        wr = (kind == 2);
        we = wr ? 1'b0 : 1'($urandom_range(0, 1));
        return make_bus(5'($urandom_range(0, 31)), we, rd, wr, 2'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
    endfunction

    // model: the stage slot and the WB slot
    logic         stage_v, stage_got, out_v;
    logic [106:0] stage_bus;
    logic [101:0] out_bus;

    logic         obs_allow, obs_req, obs_we, obs_wb_valid, obs_busy;
    logic [101:0] obs_wb_bus;
    logic [31:0]  obs_addr, obs_wdata, obs_fdata, obs_pc;
    logic [3:0]   obs_strb;
    logic [4:0]   obs_fdest;
    int           req_cnt, hs_cnt, busy_cnt;

    task automatic model_clear();
        stage_v = 1'b0; stage_got = 1'b0; out_v = 1'b0;
        stage_bus = '0; out_bus = '0;
    endtask

    task automatic step(input logic v, input logic [106:0] b, input logic wa,
                        input logic rdy, input logic r);
        logic hs, fin, ofree, xfer, acc, exp_req, s_mem, s_rd, s_wr;
        logic [1:0] s_sz; logic [31:0] s_alu, s_sd; logic [101:0] s_exp;
        ex_valid = v; ex_bus = b; wb_allowin = wa; dm_ready = rdy; rst = r; noise = $urandom;
        hs = 1'b0; xfer = 1'b0; acc = 1'b0;
        s_rd  = stage_bus[100];
        s_wr  = stage_bus[99];
        s_sz  = stage_bus[98:97];
        s_alu = stage_bus[95:64];
        s_sd  = stage_bus[63:32];
        s_mem = stage_v && (s_rd || s_wr) && is_aligned(s_sz, s_alu);
        s_exp = ref_wb(stage_bus);
        @(negedge clk);
        obs_allow = mem_allowin; obs_req = dm_req; obs_we = dm_we; obs_wb_valid = wb_valid;
        obs_busy = fwd_busy; obs_wb_bus = wb_bus; obs_addr = dm_addr; obs_wdata = dm_wdata;
        obs_fdata = fwd_data; obs_pc = ctl_pc; obs_strb = dm_wstrb; obs_fdest = fwd_dest;
        if (dm_req) req_cnt++;
        if (dm_req && dm_ready) hs_cnt++;
        if (fwd_busy) busy_cnt++;
        if (r) begin
            check("rst_allowin", mem_allowin, 1'b0);
            check("rst_dm_req", dm_req, 1'b0);
        end else begin
            exp_req = s_mem && !stage_got;
            hs      = exp_req && rdy;
            fin     = stage_v && (!s_mem || stage_got || hs);
            ofree   = !out_v || wa;
            xfer    = fin && ofree;
            acc     = v && (!stage_v || xfer);
            check("allowin", mem_allowin, !stage_v || xfer);
            check("wb_valid", wb_valid, out_v);
            if (out_v) check("wb_bus", wb_bus, out_bus);
            check("dm_req", dm_req, exp_req);
            if (exp_req) begin
                check("dm_addr", dm_addr, {s_alu[31:2], 2'b00});
                check("dm_we", dm_we, s_wr);
                if (s_wr) begin
                    check("dm_wstrb", dm_wstrb, ref_strb(s_sz, s_alu));
                    check("dm_wdata", dm_wdata, ref_wdata(s_sz, s_sd));
                end
            end
            check("fwd_dest", fwd_dest, (stage_v && s_exp[96]) ? s_exp[101:97] : 5'd0);
            check("fwd_busy", fwd_busy, stage_v && s_rd && !fin);
            check("ctl_pc", ctl_pc, stage_v ? stage_bus[31:0] : 32'h0);
            if (stage_v && fin) check("fwd_data", fwd_data, s_exp[95:64]);
        end
        @(posedge clk);
        #1;
        if (r) begin
            model_clear();
        end else begin
            if (hs) stage_got = 1'b1;
            if (xfer) begin
                out_v = 1'b1;
                out_bus = s_exp;
            end else if (wa) begin
                out_v = 1'b0;
            end
            if (acc) begin
                stage_v = 1'b1; stage_bus = b; stage_got = 1'b0;
            end else if (xfer) begin
                stage_v = 1'b0;
            end
        end
    endtask

    task automatic idle(input logic wa, input logic rdy);
        step(1'b0, '0, wa, rdy, 1'b0);
    endtask

    initial begin
        logic [106:0] b;
        logic [101:0] exp_bus;
        int wbv;
        rst = 1'b1; ex_valid = 1'b0; ex_bus = '0; wb_allowin = 1'b1; dm_ready = 1'b0; noise = '0;
        req_cnt = 0; hs_cnt = 0; busy_cnt = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // reset state
        idle(1'b1, 1'b0);
        check("reset_allowin", obs_allow, 1'b1);
        check("reset_wb_valid", obs_wb_valid, 1'b0);
        check("reset_wb_bus", obs_wb_bus, 102'h0);
        check("reset_dm_req", obs_req, 1'b0);
        check("reset_fwd", {obs_fdest, obs_fdata, obs_busy, obs_pc}, 70'h0);

        // ALU instruction: two-cycle latency, no memory access
        req_cnt = 0;
        b = make_bus(5'd5, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h1234, 32'h0, 32'h0000_0100);
        step(1'b1, b, 1'b1, 1'b0, 1'b0);
        check("add_accept", obs_allow, 1'b1);
        idle(1'b1, 1'b0);
        check("add_lat1", obs_wb_valid, 1'b0);
        idle(1'b1, 1'b0);
        check("add_lat2", obs_wb_valid, 1'b1);
        check("add_bus", obs_wb_bus, {5'd5, 1'b1, 32'h1234, 32'h0, 32'h0000_0100});
        check("add_no_req", req_cnt, 0);

        // signed byte load from the top lane after four not-ready request cycles
        b = make_bus(5'd7, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h0000_0104);
        step(1'b1, b, 1'b1, 1'b0, 1'b0);
        busy_cnt = 0;
        idle(1'b1, 1'b0);
        check("lb_addr", obs_addr, 32'h0000_1000);
        check("lb_req", obs_req, 1'b1);
        repeat (3) idle(1'b1, 1'b0);
        idle(1'b1, 1'b1);
        check("lb_busy_cycles", busy_cnt, 4);
        idle(1'b1, 1'b0);
        check("lb_valid", obs_wb_valid, 1'b1);
        check("lb_bus", obs_wb_bus, {5'd7, 1'b1, 32'hFFFF_FF80, 32'h0000_1003, 32'h0000_0104});

        // half store to the upper half-word
        b = make_bus(5'd0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000_ABCD, 32'h0000_0108);
        step(1'b1, b, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 1'b1);
        check("sh_req", obs_req, 1'b1);
        check("sh_we", obs_we, 1'b1);
        check("sh_wstrb", obs_strb, 4'b1100);
        check("sh_wdata", obs_wdata, 32'hABCD_ABCD);
        idle(1'b1, 1'b0);
        check("sh_valid", obs_wb_valid, 1'b1);
        check("sh_bus_we", obs_wb_bus[96], 1'b0);

        // misaligned word load completes without touching memory
        req_cnt = 0;
        b = make_bus(5'd9, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 32'h0000_010C);
        step(1'b1, b, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b0);
        check("lw_mis_valid", obs_wb_valid, 1'b1);
        check("lw_mis_result", obs_wb_bus[95:64], 32'h0);
        check("lw_mis_we", obs_wb_bus[96], 1'b0);
        check("lw_mis_no_req", req_cnt, 0);

        // load response arrives while WB is stalled
        idle(1'b1, 1'b0);
        b = make_bus(5'd2, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_5555, 32'h0, 32'h0000_0200);
        step(1'b1, b, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        b = make_bus(5'd3, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'h0, 32'h0000_0204);
        step(1'b1, b, 1'b0, 1'b0, 1'b0);
        hs_cnt = 0;
        idle(1'b0, 1'b1);
        check("hold_allowin_d", obs_allow, 1'b0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b0, 1'(i % 2));
            check("hold_allowin", obs_allow, 1'b0);
        end
        check("hold_single_req", hs_cnt, 1);
        idle(1'b1, 1'b0);
        check("hold_add_bus", obs_wb_bus, {5'd2, 1'b1, 32'h0000_5555, 32'h0, 32'h0000_0200});
        check("hold_release", obs_allow, 1'b1);
        idle(1'b1, 1'b0);
        exp_bus = {5'd3, 1'b1, mem_word(32'h0000_4000), 32'h0000_4000, 32'h0000_0204};
        check("hold_load_valid", obs_wb_valid, 1'b1);
        check("hold_load_bus", obs_wb_bus, exp_bus);

        // reset in the middle of a request; a late ready is ignored
        b = make_bus(5'd4, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'h0, 32'h0000_0300);
        step(1'b1, b, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        idle(1'b1, 1'b1);
        check("rstreq_dm_req", obs_req, 1'b0);
        check("rstreq_wb_valid", obs_wb_valid, 1'b0);
        check("rstreq_wb_bus", obs_wb_bus, 102'h0);
        check("rstreq_fwd", {obs_fdest, obs_fdata, obs_busy, obs_pc}, 70'h0);
        wbv = 0;
        for (int i = 0; i < 3; i++) begin
            idle(1'b1, 1'b1);
            if (obs_wb_valid) wbv++;
        end
        check("rstreq_no_pulse", wbv, 0);

        // random traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 1)), rand_bus(), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 299) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
